// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Decode table is active-low {a..g}; codes 10..15 map to all segments off.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Entry 15 is the leftmost slice, entry 0 the rightmost.
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF,
      7'b0000100,   // 9
      7'b0000000,   // 8
      7'b0001111,   // 7
      7'b0100000,   // 6
      7'b0100100,   // 5
      7'b1001100,   // 4
      7'b0000110,   // 3
      7'b0010010,   // 2
      7'b1001111,   // 1
      7'b0000001    // 0
   };

endpackage

// File: rtl/seg7_digit_decode.sv
// BCD to active-low seven-segment decoder; non-BCD codes blank the digit.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner with per-slot blanking guard and frame-aligned digit updates.
// Latency: outputs registered; a load becomes visible at the next frame boundary (at once when idle).
// Backpressure: none; load is a pulse, the last one before a frame end wins. SEG7_SCAN_LZ_BLANK_EN adds leading-zero blanking.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_done
);
   import seg7_pkg::*;

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int DW    = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t      state, ns;
   logic [CNT_W-1:0] div_cnt, ncnt;
   logic [IDX_W-1:0] digit_idx, nidx;
   logic             fd_nxt;

   logic [DW-1:0]    active, active_nxt;
   logic [DW-1:0]    pending, pending_nxt;
   logic             pending_valid, pv_nxt;

   logic [DW-1:0]    shifted;
   logic [3:0]       nib;
   logic [6:0]       dec_seg;
   logic [6:0]       seg_nxt;
   logic [NUM_DIGITS-1:0] an_nxt;

   always_comb begin
      ns     = state;
      ncnt   = div_cnt;
      nidx   = digit_idx;
      fd_nxt = 1'b0;
      if (!enable) begin
         ns   = IDLE;
         ncnt = '0;
         nidx = '0;
      end else begin
         case (state)
            IDLE: begin
               ns   = BLANK;
               ncnt = '0;
               nidx = '0;
            end
            BLANK, SHOW: begin
               if (div_cnt == LAST_CNT) begin
                  ns   = BLANK;
                  ncnt = '0;
                  if (digit_idx == LAST_IDX) begin
                     nidx   = '0;
                     fd_nxt = 1'b1;
                  end else begin
                     nidx = digit_idx + IDX_W'(1);
                  end
               end else begin
                  ncnt = div_cnt + CNT_W'(1);
                  ns   = (div_cnt >= BLANK_LAST) ? SHOW : BLANK;
               end
            end
            default: begin
               ns   = IDLE;
               ncnt = '0;
               nidx = '0;
            end
         endcase
      end
   end

   // The transfer is taken in the frame_done cycle (first guard cycle of digit 0),
   // so it is never visible mid-digit and a load in that same cycle can bypass pending.
   always_comb begin
      active_nxt  = active;
      pending_nxt = pending;
      pv_nxt      = pending_valid;
      if (frame_done && pending_valid) begin
         active_nxt = pending;
         pv_nxt     = 1'b0;
      end
      if (load) begin
         if (state == IDLE || frame_done) begin
            active_nxt = digits_in;
            pv_nxt     = 1'b0;
         end else begin
            pending_nxt = digits_in;
            pv_nxt      = 1'b1;
         end
      end
   end

   assign shifted = active_nxt >> {nidx, 2'b00};
   assign nib     = shifted[3:0];

   seg7_digit_decode u_dec (
      .bcd (nib),
      .seg (dec_seg)
   );

`ifdef SEG7_SCAN_LZ_BLANK_EN
   logic lz_hit;
   // Blank when this nibble and every higher one are zero; digit 0 always shows.
   assign lz_hit = (nidx != '0) && (shifted == '0);
`endif

   always_comb begin
      seg_nxt = SEG_OFF;
      an_nxt  = '1;
      if (ns == SHOW) begin
         an_nxt  = ~(NUM_DIGITS'(1) << nidx);
         seg_nxt = dec_seg;
`ifdef SEG7_SCAN_LZ_BLANK_EN
         if (lz_hit) seg_nxt = SEG_OFF;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         div_cnt       <= '0;
         digit_idx     <= '0;
         active        <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
         seg_out       <= SEG_OFF;
         an_out        <= '1;
         frame_done    <= 1'b0;
      end else begin
         state         <= ns;
         div_cnt       <= ncnt;
         digit_idx     <= nidx;
         active        <= active_nxt;
         pending       <= pending_nxt;
         pending_valid <= pv_nxt;
         seg_out       <= seg_nxt;
         an_out        <= an_nxt;
         frame_done    <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] digits_in;
   logic [6:0]  seg_out;
   logic [3:0]  an_out;
   logic        frame_done;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [6:0] OFF = 7'b1111111;
   localparam logic [6:0] S0  = 7'b0000001;
   localparam logic [6:0] S1  = 7'b1001111;
   localparam logic [6:0] S2  = 7'b0010010;
   localparam logic [6:0] S3  = 7'b0000110;
   localparam logic [6:0] S4  = 7'b1001100;
   localparam logic [6:0] S5  = 7'b0100100;
   localparam logic [6:0] S7  = 7'b0001111;
   localparam logic [6:0] S8  = 7'b0000000;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .digits_in  (digits_in),
      .seg_out    (seg_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic skip(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Expected pattern after optional leading-zero blanking of value v at digit d.
   function automatic logic [6:0] lzx(input logic [15:0] v, input int d, input logic [6:0] s);
`ifdef SEG7_SCAN_LZ_BLANK_EN
      if (d != 0 && (v >> (4 * d)) == 16'h0) return OFF;
`endif
      return s;
   endfunction

   task automatic count_to_fd(output int n);
      n = 0;
      while (frame_done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (frame_done !== 1'b1) n = -1;
   endtask

   // Waits for frame_done, optionally loads in that cycle, then samples the first SHOW cycle of each digit.
   task automatic collect_frame(input bit do_ld, input logic [15:0] ld, output bit ok,
                                output logic [3:0][6:0] sg, output logic [3:0][3:0] an);
      int n;
      ok = 1'b0;
      sg = '1;
      an = '1;
      count_to_fd(n);
      if (n >= 0) begin
         ok = 1'b1;
         if (do_ld) begin
            load      = 1'b1;
            digits_in = ld;
         end
         tick();
         load = 1'b0;
         tick();
         for (int d = 0; d < 4; d++) begin
            sg[d] = seg_out;
            an[d] = an_out;
            skip(8);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = 16'h0;
      skip(2);
      vectors += 3;
      if (seg_out !== OFF)     begin miscompares++; $display("FAIL reset_seg: seg_out=%b expected %b", seg_out, OFF); end
      if (an_out !== 4'hF)     begin miscompares++; $display("FAIL reset_an: an_out=%b expected 1111", an_out); end
      if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd: frame_done=%b expected 0", frame_done); end
      rst_n = 1'b1;
      skip(3);
      vectors += 2;
      if (an_out !== 4'hF || seg_out !== OFF) begin miscompares++; $display("FAIL idle_off: an_out=%b seg_out=%b expected 1111/%b", an_out, seg_out, OFF); end
      if (frame_done !== 1'b0) begin miscompares++; $display("FAIL idle_fd: frame_done=%b expected 0", frame_done); end
   endtask

   task automatic test_basic_scan();
      int n;
      bit ok;
      logic [3:0][6:0] sg, exp;
      logic [3:0][3:0] an;
      enable = 1'b1; load = 1'b1; digits_in = 16'h1234;
      tick();
      load = 1'b0;
      vectors += 2;
      if (an_out !== 4'hF || seg_out !== OFF) begin miscompares++; $display("FAIL first_blank: an_out=%b seg_out=%b expected 1111/%b", an_out, seg_out, OFF); end
      if (frame_done !== 1'b0) begin miscompares++; $display("FAIL first_fd: frame_done=%b expected 0", frame_done); end
      tick();
      vectors++;
      if (an_out !== 4'hF) begin miscompares++; $display("FAIL second_blank: an_out=%b expected 1111", an_out); end
      for (int k = 0; k < 6; k++) begin
         tick();
         vectors++;
         if (an_out !== 4'b1110 || seg_out !== S4) begin
            miscompares++;
            $display("FAIL d0_show%0d: an_out=%b seg_out=%b expected 1110/%b", k, an_out, seg_out, S4);
         end
      end
      tick();
      vectors++;
      if (an_out !== 4'hF || seg_out !== OFF) begin miscompares++; $display("FAIL d1_blank: an_out=%b seg_out=%b expected 1111/%b", an_out, seg_out, OFF); end
      skip(2);
      vectors++;
      if (an_out !== 4'b1101 || seg_out !== S3) begin miscompares++; $display("FAIL d1_show: an_out=%b seg_out=%b expected 1101/%b", an_out, seg_out, S3); end
      count_to_fd(n);
      vectors++;
      if (n !== 22) begin miscompares++; $display("FAIL first_frame_len: cycles=%0d expected 22", n); end
      tick();
      count_to_fd(n);
      vectors++;
      if (n !== 31) begin miscompares++; $display("FAIL frame_period: cycles=%0d expected 31", n); end
      exp = {S1, S2, S3, S4};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL basic_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors += 2;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL basic_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
         if (an[d] !== ~(4'b0001 << d)) begin miscompares++; $display("FAIL basic_an d%0d: an_out=%b expected %b", d, an[d], ~(4'b0001 << d)); end
      end
   endtask

   task automatic test_pending_last_wins();
      bit ok;
      logic [3:0][6:0] sg, exp;
      logic [3:0][3:0] an;
      load = 1'b1; digits_in = 16'h0009;
      tick();
      load = 1'b0;
      vectors++;
      if (an_out !== 4'b1110 || seg_out !== S4) begin miscompares++; $display("FAIL pend_hold1: an_out=%b seg_out=%b expected 1110/%b", an_out, seg_out, S4); end
      tick();
      load = 1'b1; digits_in = 16'h0005;
      tick();
      load = 1'b0;
      tick();
      vectors++;
      if (seg_out !== S4) begin miscompares++; $display("FAIL pend_hold2: seg_out=%b expected %b", seg_out, S4); end
      exp = {lzx(16'h0005, 3, S0), lzx(16'h0005, 2, S0), lzx(16'h0005, 1, S0), S5};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL pend_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors += 2;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL pend_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
         if (an[d] !== ~(4'b0001 << d)) begin miscompares++; $display("FAIL pend_an d%0d: an_out=%b expected %b", d, an[d], ~(4'b0001 << d)); end
      end
   endtask

   task automatic test_load_at_frame_end();
      bit ok;
      logic [3:0][6:0] sg;
      logic [3:0][3:0] an;
      collect_frame(1'b1, 16'h8888, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL fe_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (sg[d] !== S8) begin miscompares++; $display("FAIL fe_seg d%0d: seg_out=%b expected %b", d, sg[d], S8); end
      end
      vectors++;
      if (dut.pending_valid !== 1'b0) begin miscompares++; $display("FAIL fe_pending_valid: pending_valid=%b expected 0", dut.pending_valid); end
   endtask

   task automatic test_invalid_codes();
      bit ok;
      logic [3:0][6:0] sg, exp;
      logic [3:0][3:0] an;
      load = 1'b1; digits_in = 16'h00AF;
      tick();
      load = 1'b0;
      exp = {lzx(16'h00AF, 3, S0), lzx(16'h00AF, 2, S0), OFF, OFF};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL inv_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors += 2;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL inv_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
         if (an[d] !== ~(4'b0001 << d)) begin miscompares++; $display("FAIL inv_an d%0d: an_out=%b expected %b", d, an[d], ~(4'b0001 << d)); end
      end
      vectors++;
      if ($isunknown(sg)) begin miscompares++; $display("FAIL inv_xcheck: seg samples=%h expected no X", sg); end
   endtask

   task automatic test_enable_drop();
      int n, bad;
      bit ok;
      logic [3:0][6:0] sg, exp;
      logic [3:0][3:0] an;
      count_to_fd(n);
      skip(18);
      load = 1'b1; digits_in = 16'h0777;
      tick();
      load = 1'b0;
      vectors++;
      if (an_out !== 4'b1011 || seg_out !== lzx(16'h00AF, 2, S0)) begin
         miscompares++;
         $display("FAIL drop_pre: an_out=%b seg_out=%b expected 1011/%b", an_out, seg_out, lzx(16'h00AF, 2, S0));
      end
      enable = 1'b0;
      tick();
      vectors++;
      if (an_out !== 4'hF || seg_out !== OFF || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_off: an_out=%b seg_out=%b frame_done=%b expected 1111/%b/0", an_out, seg_out, frame_done, OFF);
      end
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (frame_done !== 1'b0 || an_out !== 4'hF || seg_out !== OFF) bad++;
      end
      vectors++;
      if (bad !== 0) begin miscompares++; $display("FAIL drop_parked: active cycles=%0d expected 0", bad); end
      enable = 1'b1;
      tick();
      vectors++;
      if (an_out !== 4'hF || seg_out !== OFF || frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL rearm_blank: an_out=%b seg_out=%b frame_done=%b expected 1111/%b/0", an_out, seg_out, frame_done, OFF);
      end
      skip(2);
      vectors++;
      if (an_out !== 4'b1110 || seg_out !== OFF) begin miscompares++; $display("FAIL rearm_d0: an_out=%b seg_out=%b expected 1110/%b", an_out, seg_out, OFF); end
      count_to_fd(n);
      vectors++;
      if (n !== 30) begin miscompares++; $display("FAIL rearm_frame_len: cycles=%0d expected 30", n); end
      exp = {lzx(16'h0777, 3, S0), S7, S7, S7};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rearm_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL rearm_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
      end
   endtask

   task automatic test_reset_mid_slot();
      int n;
      bit ok;
      logic [3:0][6:0] sg, exp;
      logic [3:0][3:0] an;
      load = 1'b1; digits_in = 16'h0123;
      tick();
      load = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      vectors += 3;
      if (seg_out !== OFF)     begin miscompares++; $display("FAIL arst_seg: seg_out=%b expected %b", seg_out, OFF); end
      if (an_out !== 4'hF)     begin miscompares++; $display("FAIL arst_an: an_out=%b expected 1111", an_out); end
      if (frame_done !== 1'b0) begin miscompares++; $display("FAIL arst_fd: frame_done=%b expected 0", frame_done); end
      tick();
      rst_n = 1'b1;
      tick();
      vectors++;
      if (an_out !== 4'hF || seg_out !== OFF) begin miscompares++; $display("FAIL arst_blank: an_out=%b seg_out=%b expected 1111/%b", an_out, seg_out, OFF); end
      skip(2);
      vectors++;
      if (an_out !== 4'b1110 || seg_out !== S0) begin miscompares++; $display("FAIL arst_d0: an_out=%b seg_out=%b expected 1110/%b", an_out, seg_out, S0); end
      count_to_fd(n);
      vectors++;
      if (n !== 30) begin miscompares++; $display("FAIL arst_frame_len: cycles=%0d expected 30", n); end
      exp = {lzx(16'h0, 3, S0), lzx(16'h0, 2, S0), lzx(16'h0, 1, S0), S0};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL arst_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL arst_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
      end
   endtask

   task automatic test_leading_zero();
      bit ok;
      logic [3:0][6:0] sg, exp;
      logic [3:0][3:0] an;
      load = 1'b1; digits_in = 16'h0040;
      tick();
      load = 1'b0;
      exp = {lzx(16'h0040, 3, S0), lzx(16'h0040, 2, S0), S4, S0};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL lz40_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors += 2;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL lz40_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
         if (an[d] !== ~(4'b0001 << d)) begin miscompares++; $display("FAIL lz40_an d%0d: an_out=%b expected %b", d, an[d], ~(4'b0001 << d)); end
      end
      load = 1'b1; digits_in = 16'h0000;
      tick();
      load = 1'b0;
      exp = {lzx(16'h0, 3, S0), lzx(16'h0, 2, S0), lzx(16'h0, 1, S0), S0};
      collect_frame(1'b0, 16'h0, ok, sg, an);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL lz00_timeout: frame_done=0 expected 1"); end
      for (int d = 0; d < 4; d++) begin
         vectors++;
         if (sg[d] !== exp[d]) begin miscompares++; $display("FAIL lz00_seg d%0d: seg_out=%b expected %b", d, sg[d], exp[d]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_pending_last_wins();
      test_load_at_frame_end();
      test_invalid_codes();
      test_enable_drop();
      test_reset_mid_slot();
      test_leading_zero();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
